// File: rtl/icache_refill_ctrl_pkg.sv
// Shared definitions for the instruction-cache refill sequencer.
// Contents: state encoding, replacement LFSR constants and line-offset constants.
package icache_refill_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        FILL  = 2'd3
    } refill_state_t;

    // Taps for x^8+x^6+x^5+x^4+1 when the register shifts left (bits 7,5,4,3).
    localparam logic [7:0] LFSR_TAP_MASK = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;

    localparam logic [2:0] LINE_OFS_W0 = 3'b000;
    localparam logic [2:0] LINE_OFS_W1 = 3'b100;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAP_MASK)};
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_lfsr.sv
// 8-bit Fibonacci LFSR used to pick the replacement victim.
// It advances only when enabled and reloads its seed on synchronous reset.
module refill_lfsr
    import icache_refill_ctrl_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED_DEF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       en,
    output logic [7:0] lfsr
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= lfsr_step(lfsr);
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Miss/refill sequencer: fetches a 2-word line in two beats, then strobes it into the cache.
// While a refill is in flight, Stall holds the pipeline; a redirect squashes the line once both beats have been received.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int         WAYS      = 4,
    parameter int         IDX_W     = 2,
    parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      PC,
    input  logic             NOT_JUMPED,
    input  logic             Hit,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             Access_MM,
    output logic [63:0]      Data_MM,
    output logic [IDX_W-1:0] victim,
    output logic             Stall,
    output logic [19:0]      CNT_REFILL,
    output logic [19:0]      CNT_ABORT
);

    refill_state_t     state, state_d;
    logic [28:0]       line_q, line_d;
    logic              abort_q, abort_d;
    logic              mem_req_d;
    logic [31:0]       mem_addr_d;
    logic              access_d;
    logic [63:0]       data_d;
    logic [IDX_W-1:0]  victim_d;
    logic              stall_d;
    logic [19:0]       cnt_refill_d, cnt_abort_d;
    logic [7:0]        lfsr;
    logic              lfsr_en;
    logic              squash;
    logic              unused_pc;

    assign squash    = ~NOT_JUMPED;
    assign unused_pc = ^PC[2:0];

    refill_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .CLK   (CLK),
        .RESET (RESET),
        .en    (lfsr_en),
        .lfsr  (lfsr)
    );

    always_comb begin
        state_d      = state;
        line_d       = line_q;
        abort_d      = abort_q;
        mem_req_d    = mem_req;
        mem_addr_d   = mem_addr;
        access_d     = 1'b0;
        data_d       = Data_MM;
        victim_d     = victim;
        cnt_refill_d = CNT_REFILL;
        cnt_abort_d  = CNT_ABORT;
        lfsr_en      = 1'b0;

        unique case (state)
            IDLE: begin
                if (!Hit && NOT_JUMPED) begin
                    line_d     = PC[31:3];
                    mem_addr_d = {PC[31:3], LINE_OFS_W0};
                    mem_req_d  = 1'b1;
                    state_d    = BEAT0;
                end
            end
            BEAT0: begin
                if (squash) abort_d = 1'b1;
                if (mem_ack) begin
                    data_d[63:32] = mem_rdata;
                    mem_addr_d    = {line_q, LINE_OFS_W1};
                    state_d       = BEAT1;
                end
            end
            BEAT1: begin
                if (squash) abort_d = 1'b1;
                if (mem_ack) begin
                    data_d[31:0] = mem_rdata;
                    mem_req_d    = 1'b0;
                    // A redirect landing on the final beat also makes the line stale.
                    if (abort_q || squash) begin
                        cnt_abort_d = CNT_ABORT + 20'd1;
                        state_d     = IDLE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                access_d     = 1'b1;
                victim_d     = IDX_W'(32'(lfsr) % 32'(WAYS));
                cnt_refill_d = CNT_REFILL + 20'd1;
                lfsr_en      = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) abort_d = 1'b0;
        stall_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            line_q     <= '0;
            abort_q    <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            Access_MM  <= 1'b0;
            Data_MM    <= '0;
            victim     <= '0;
            Stall      <= 1'b0;
            CNT_REFILL <= '0;
            CNT_ABORT  <= '0;
        end else begin
            state      <= state_d;
            line_q     <= line_d;
            abort_q    <= abort_d;
            mem_req    <= mem_req_d;
            mem_addr   <= mem_addr_d;
            Access_MM  <= access_d;
            Data_MM    <= data_d;
            victim     <= victim_d;
            Stall      <= stall_d;
            CNT_REFILL <= cnt_refill_d;
            CNT_ABORT  <= cnt_abort_d;
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: drives misses against a scripted memory port.
// Expected lines and victims are queued when a refill is issued and popped when Access_MM fires.
module tb_icache_refill_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] PC;
    logic        NOT_JUMPED;
    logic        Hit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        Access_MM;
    logic [63:0] Data_MM;
    logic [1:0]  victim;
    logic        Stall;
    logic [19:0] CNT_REFILL;
    logic [19:0] CNT_ABORT;

    icache_refill_ctrl #(.WAYS(4), .IDX_W(2), .LFSR_SEED(8'hA5)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .PC         (PC),
        .NOT_JUMPED (NOT_JUMPED),
        .Hit        (Hit),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .Access_MM  (Access_MM),
        .Data_MM    (Data_MM),
        .victim     (victim),
        .Stall      (Stall),
        .CNT_REFILL (CNT_REFILL),
        .CNT_ABORT  (CNT_ABORT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  vic;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  mdl_lfsr = 8'hA5;
    logic [19:0] exp_refill = '0;
    logic [19:0] exp_abort  = '0;
    logic        prev_acc = 1'b0;

    function automatic logic [7:0] mdl_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard consumer: every Access_MM pulse must match the oldest queued line.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (Access_MM === 1'b1) begin
                check("acc_1cyc", {63'd0, prev_acc}, 64'd0);
                if (sb_q.size() == 0) begin
                    check("acc_spurious", {63'd0, Access_MM}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("data_mm", Data_MM, e.data);
                    check("victim", {62'd0, victim}, {62'd0, e.vic});
                end
            end
            prev_acc = Access_MM;
        end
    end

    task automatic refill(input logic [31:0] pc, input logic [31:0] w0, input logic [31:0] w1,
                          input int wt0, input int wt1, input bit sq);
        int lat;
        PC = pc; Hit = 1'b0; NOT_JUMPED = 1'b1;
        step(); lat = 1; Hit = 1'b1;
        check("b0_req", {63'd0, mem_req}, 64'd1);
        check("b0_addr", {32'd0, mem_addr}, {32'd0, pc[31:3], 3'b000});
        check("b0_stall", {63'd0, Stall}, 64'd1);
        if (sq) NOT_JUMPED = 1'b0;
        repeat (wt0) begin
            step(); lat++;
            NOT_JUMPED = 1'b1;
            check("b0_wait_req", {63'd0, mem_req}, 64'd1);
            check("b0_wait_stall", {63'd0, Stall}, 64'd1);
        end
        mem_ack = 1'b1; mem_rdata = w0;
        step(); lat++;
        mem_ack = 1'b0; mem_rdata = $urandom; NOT_JUMPED = 1'b1;
        check("b1_addr", {32'd0, mem_addr}, {32'd0, pc[31:3], 3'b100});
        check("b1_req", {63'd0, mem_req}, 64'd1);
        repeat (wt1) begin
            step(); lat++;
            check("b1_wait_req", {63'd0, mem_req}, 64'd1);
            check("b1_wait_stall", {63'd0, Stall}, 64'd1);
        end
        mem_ack = 1'b1; mem_rdata = w1;
        step(); lat++;
        mem_ack = 1'b0; mem_rdata = $urandom;
        check("req_drop", {63'd0, mem_req}, 64'd0);
        if (sq) begin
            exp_abort++;
            check("abort_stall", {63'd0, Stall}, 64'd0);
            check("cnt_abort", {44'd0, CNT_ABORT}, {44'd0, exp_abort});
            repeat (3) step();
            check("abort_refill_cnt", {44'd0, CNT_REFILL}, {44'd0, exp_refill});
        end else begin
            sb_q.push_back('{data: {w0, w1}, vic: mdl_lfsr[1:0]});
            mdl_lfsr = mdl_next(mdl_lfsr);
            exp_refill++;
            check("fill_stall", {63'd0, Stall}, 64'd1);
            while (Access_MM !== 1'b1 && lat < 30) begin
                step(); lat++;
            end
            check("latency", 64'(lat), 64'(4 + wt0 + wt1));
            check("post_stall", {63'd0, Stall}, 64'd0);
            check("cnt_refill", {44'd0, CNT_REFILL}, {44'd0, exp_refill});
        end
    endtask

    initial begin
        RESET = 1'b1; PC = '0; NOT_JUMPED = 1'b1; Hit = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        step(); step();
        check("rst_req", {63'd0, mem_req}, 64'd0);
        check("rst_addr", {32'd0, mem_addr}, 64'd0);
        check("rst_acc", {63'd0, Access_MM}, 64'd0);
        check("rst_data", Data_MM, 64'd0);
        check("rst_victim", {62'd0, victim}, 64'd0);
        check("rst_stall", {63'd0, Stall}, 64'd0);
        check("rst_cnt_r", {44'd0, CNT_REFILL}, 64'd0);
        check("rst_cnt_a", {44'd0, CNT_ABORT}, 64'd0);
        RESET = 1'b0;
        step();

        // Zero-wait refill, then the same miss with three wait cycles per beat.
        refill(32'h48, 32'h11111111, 32'h22222222, 0, 0, 1'b0);
        refill(32'h48, 32'h33333333, 32'h44444444, 3, 3, 1'b0);

        // Redirect during BEAT0: both beats finish, line dropped.
        refill(32'h1000, 32'hDEADBEEF, 32'hCAFEF00D, 1, 2, 1'b1);

        // Redirect on the same edge as a miss: nothing starts.
        PC = 32'h200; Hit = 1'b0; NOT_JUMPED = 1'b0;
        step();
        Hit = 1'b1; NOT_JUMPED = 1'b1;
        check("jmp_miss_req", {63'd0, mem_req}, 64'd0);
        check("jmp_miss_stall", {63'd0, Stall}, 64'd0);

        // Reset while in BEAT1.
        PC = 32'h300; Hit = 1'b0;
        step(); Hit = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        step(); mem_ack = 1'b0;
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        mdl_lfsr = 8'hA5; exp_refill = '0; exp_abort = '0;
        check("bt1rst_req", {63'd0, mem_req}, 64'd0);
        check("bt1rst_stall", {63'd0, Stall}, 64'd0);
        check("bt1rst_acc", {63'd0, Access_MM}, 64'd0);
        check("bt1rst_data", Data_MM, 64'd0);
        check("bt1rst_cnt_r", {44'd0, CNT_REFILL}, 64'd0);
        check("bt1rst_cnt_a", {44'd0, CNT_ABORT}, 64'd0);
        step(); step();

        // Back-to-back misses: victims walk the LFSR from the seed (01, 10, 01).
        refill(32'h2008, 32'hA0A0A0A0, 32'hB1B1B1B1, 0, 0, 1'b0);
        refill(32'h2010, 32'hC2C2C2C2, 32'hD3D3D3D3, 0, 1, 1'b0);
        refill(32'h2018, 32'hE4E4E4E4, 32'hF5F5F5F5, 2, 0, 1'b0);

        // Hits with spurious acks: nothing moves.
        Hit = 1'b1;
        for (int i = 0; i < 100; i++) begin
            PC = $urandom;
            mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            step();
            check("hit_req", {63'd0, mem_req}, 64'd0);
            check("hit_stall", {63'd0, Stall}, 64'd0);
        end
        mem_ack = 1'b0;
        check("hit_cnt_r", {44'd0, CNT_REFILL}, {44'd0, exp_refill});
        check("hit_cnt_a", {44'd0, CNT_ABORT}, {44'd0, exp_abort});
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
